pkt_stream_checker: RTL
=======================

# pkt_stream_checker

Downstream sink for the FIFO/CPU packet path. It consumes the 64-bit data / 8-bit ctrl packet stream that the convertable FIFO controller emits on its output port. It checks every packet against the test-data packet format: header, sequence number, length, payload pattern and end-of-packet marking. It drives programmable back-pressure on the ready line and exposes packet, word and error counters for the bench and for later chip-level status readout.

## Interface
Parameters:
- DATA_WIDTH, 64, stream data width; only 64 is supported.
- CTRL_WIDTH, 8, stream ctrl width.
- MAX_LEN, 256, maximum legal packet length in words, header included.
- BP_EN, 0, 1 enables LFSR back-pressure on in_rdy.
- LFSR_SEED, 16'hACE1, reset seed of the back-pressure LFSR; must be non-zero.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  64  stream data.
- in_ctrl  in  8  stream ctrl.
- in_wr  in  1  word valid.
- in_rdy  out  1  checker can accept a word this cycle.
- pkt_ok_cnt  out  32  count of packets that passed all checks; wraps.
- word_cnt  out  32  count of accepted words; wraps.
- err_cnt  out  16  count of detected errors; saturates at 16'hFFFF.
- err_sticky  out  1  set on the first error; cleared only by reset.
- last_err  out  3  code of the most recent error.
- busy  out  1  high while mid-packet (state BODY or DRAIN).

## Operation
Packet format (len = total words, 2..MAX_LEN):
- Header word: in_ctrl=8'hFF; data = {16'hC0DE, seq[15:0], 16'h0000, len[15:0]}.
- Body word k (k = 1..len-1): data = {16'h0000, seq[15:0], 16'h0000, k[15:0]}.
- Ctrl per body word: in_ctrl=8'h00 for k < len-1; non-zero and not 8'hFF for k = len-1 (EOP).

Acceptance:
- A word is accepted when in_wr=1 and in_rdy=1 in the same cycle.
- in_wr=1 with in_rdy=0 is error 7 (OVERRUN). The word is discarded and the state is unchanged.
- word_cnt increments on every accepted word.

FSM, states IDLE, BODY, DRAIN; reset state IDLE:
- IDLE: the accepted word must be a header with ctrl=FF, correct marker, and 2 ≤ len ≤ MAX_LEN.
  - Good header: latch len and seq, set k=1, go to BODY.
  - Header with seq ≠ exp_seq: error 2 (SEQ), still go to BODY, mark the packet bad.
  - After any header: exp_seq ← rx seq + 1 (resync).
  - ctrl=FF with bad marker or bad len: error 1 (BAD_HDR), go to DRAIN.
  - Any other word: error 6 (UNEXPECTED), stay in IDLE.
- BODY, priority order per word:
  - ctrl=FF: error 1 (BAD_HDR), go to DRAIN.
  - Non-zero ctrl with k < len-1: error 4 (EARLY_EOP), go to IDLE.
  - ctrl=0 with k = len-1: error 5 (MISSING_EOP), go to DRAIN.
  - Data mismatch: error 3 (PAYLOAD), mark the packet bad. Only the first mismatch in a packet is counted.
  - On a valid EOP word: go to IDLE; pkt_ok_cnt increments only if the packet is not marked bad.
- DRAIN: discard words until a non-zero, non-FF ctrl word, then go to IDLE. No further errors are counted in DRAIN.

Error reporting:
- One error at most per accepted word. OVERRUN is also at most one per cycle.
- Every error: err_cnt increments (saturating), last_err takes the code, err_sticky is set.

Back-pressure:
- 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle.
- in_rdy = 1 when BP_EN=0; otherwise in_rdy = lfsr[0] | lfsr[1] (nominally 75% ready).

## Timing
- All outputs are registered. Reset values: in_rdy=0, every counter 0, err_sticky=0, last_err=0, busy=0, exp_seq=0, lfsr=LFSR_SEED.
- First cycle after rst_n deasserts: in_rdy=1 (BP_EN=0) or the LFSR-derived value.
- Counters, last_err, err_sticky and busy reflect an accepted word one cycle after the acceptance edge. Latency is 1, throughput 1 word/cycle.
- in_rdy depends only on the LFSR, never on in_wr; there is no combinational path from input to in_rdy.
- Error and OVERRUN in the same cycle are impossible, since an overrun word is not accepted.
- rst_n asserted mid-packet: immediate return to IDLE, all state cleared. The next packet must start with a header carrying seq 0, or error 2 is flagged.
- err_cnt holds at 16'hFFFF. pkt_ok_cnt and word_cnt wrap from 32'hFFFFFFFF to 0.

## Test plan
- BP_EN=0, send 3 good packets (seq 0,1,2; len 2,5,256) -> pkt_ok_cnt=3, word_cnt=263, err_cnt=0, err_sticky=0.
- Good packet seq 0, then seq 5 len 4 -> err_cnt=1, last_err=2, pkt_ok_cnt=1; a following seq 6 packet counts as ok (pkt_ok_cnt=2).
- Packet len 6 with EOP ctrl on word 3 -> last_err=4, state IDLE; the next good header is accepted without extra errors.
- Header with len=1, then 4 body words ending in EOP, then a good packet -> exactly one error (code 1), pkt_ok_cnt=1.
- BP_EN=1, driver asserts in_wr ignoring in_rdy -> err_cnt equals the number of in_wr&!in_rdy cycles, last_err=7; a compliant driver gives err_cnt=0.
- Assert rst_n low during word 3 of a len-8 packet -> all outputs at reset values next cycle; a fresh seq-0 packet passes.

Source files
------------

// File: rtl/pkt_stream_checker.sv
// Sink-side checker for the 64-bit data / 8-bit ctrl test packet stream.
// Validates header, sequence, length, payload and EOP; keeps status counters.
module pkt_stream_checker #(
   parameter int          DATA_WIDTH = 64,
   parameter int          CTRL_WIDTH = 8,
   parameter int          MAX_LEN    = 256,
   parameter int          BP_EN      = 0,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [31:0]           pkt_ok_cnt,
   output logic [31:0]           word_cnt,
   output logic [15:0]           err_cnt,
   output logic                  err_sticky,
   output logic [2:0]            last_err,
   output logic                  busy,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BODY  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [2:0] ERR_BAD_HDR     = 3'd1;
   localparam logic [2:0] ERR_SEQ         = 3'd2;
   localparam logic [2:0] ERR_PAYLOAD     = 3'd3;
   localparam logic [2:0] ERR_EARLY_EOP   = 3'd4;
   localparam logic [2:0] ERR_MISSING_EOP = 3'd5;
   localparam logic [2:0] ERR_UNEXPECTED  = 3'd6;
   localparam logic [2:0] ERR_OVERRUN     = 3'd7;

   localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] seq_q, seq_d;
   logic [15:0] k_q, k_d;
   logic [15:0] exp_seq_q, exp_seq_d;
   logic        pkt_bad_q, pkt_bad_d;
   logic        pay_err_q, pay_err_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic        rdy_q, rdy_d;
   logic [31:0] pkt_ok_q, pkt_ok_d;
   logic [31:0] word_q, word_d;
   logic [15:0] err_q, err_d;
   logic        sticky_q, sticky_d;
   logic [2:0]  last_err_q, last_err_d;
   logic        busy_q, busy_d;

   logic        accept;
   logic        ctrl_ff;
   logic        ctrl_zero;
   logic [15:0] hdr_seq;
   logic [15:0] hdr_len;
   logic        hdr_ok;
   logic        last_word;
   logic        data_match;
   logic        err_v;
   logic [2:0]  err_code;
   logic        pkt_inc;
   logic        lfsr_fb;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      seq_d      = seq_q;
      k_d        = k_q;
      exp_seq_d  = exp_seq_q;
      pkt_bad_d  = pkt_bad_q;
      pay_err_d  = pay_err_q;
      pkt_ok_d   = pkt_ok_q;
      word_d     = word_q;
      err_d      = err_q;
      sticky_d   = sticky_q;
      last_err_d = last_err_q;
      err_v      = 1'b0;
      err_code   = 3'd0;
      pkt_inc    = 1'b0;

      // Fibonacci LFSR, taps 16,14,13,11; in_rdy is a registered function of it only
      lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
      lfsr_d  = {lfsr_q[14:0], lfsr_fb};
      rdy_d   = (BP_EN != 0) ? (lfsr_d[0] | lfsr_d[1]) : 1'b1;

      accept     = in_wr & rdy_q;
      ctrl_ff    = (in_ctrl == '1);
      ctrl_zero  = (in_ctrl == '0);
      hdr_seq    = in_data[47:32];
      hdr_len    = in_data[15:0];
      hdr_ok     = (in_data[63:48] == 16'hC0DE) && (hdr_len >= 16'd2) &&
                   (hdr_len <= MAX_LEN_W);
      last_word  = (k_q == len_q - 16'd1);
      data_match = (in_data == {16'h0000, seq_q, 16'h0000, k_q});

      if (in_wr && !rdy_q) begin
         err_v    = 1'b1;
         err_code = ERR_OVERRUN;
      end else if (accept) begin
         word_d = word_q + 32'd1;
         case (state_q)
            ST_IDLE: begin
               if (ctrl_ff && hdr_ok) begin
                  len_d     = hdr_len;
                  seq_d     = hdr_seq;
                  k_d       = 16'd1;
                  pay_err_d = 1'b0;
                  pkt_bad_d = (hdr_seq != exp_seq_q);
                  exp_seq_d = hdr_seq + 16'd1;
                  state_d   = ST_BODY;
                  if (hdr_seq != exp_seq_q) begin
                     err_v    = 1'b1;
                     err_code = ERR_SEQ;
                  end
               end else if (ctrl_ff) begin
                  err_v    = 1'b1;
                  err_code = ERR_BAD_HDR;
                  state_d  = ST_DRAIN;
               end else begin
                  err_v    = 1'b1;
                  err_code = ERR_UNEXPECTED;
               end
            end
            ST_BODY: begin
               if (ctrl_ff) begin
                  err_v    = 1'b1;
                  err_code = ERR_BAD_HDR;
                  state_d  = ST_DRAIN;
               end else if (!ctrl_zero && !last_word) begin
                  err_v    = 1'b1;
                  err_code = ERR_EARLY_EOP;
                  state_d  = ST_IDLE;
               end else if (ctrl_zero && last_word) begin
                  err_v    = 1'b1;
                  err_code = ERR_MISSING_EOP;
                  state_d  = ST_DRAIN;
               end else begin
                  // Only the first payload mismatch of a packet is reported
                  if (!data_match) begin
                     pkt_bad_d = 1'b1;
                     pay_err_d = 1'b1;
                     if (!pay_err_q) begin
                        err_v    = 1'b1;
                        err_code = ERR_PAYLOAD;
                     end
                  end
                  if (last_word) begin
                     state_d = ST_IDLE;
                     pkt_inc = !pkt_bad_q && data_match;
                  end else begin
                     k_d = k_q + 16'd1;
                  end
               end
            end
            ST_DRAIN: begin
               if (!ctrl_zero && !ctrl_ff) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (err_v) begin
         if (err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
         end
         last_err_d = err_code;
         sticky_d   = 1'b1;
      end
      if (pkt_inc) begin
         pkt_ok_d = pkt_ok_q + 32'd1;
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= 16'd0;
         seq_q      <= 16'd0;
         k_q        <= 16'd0;
         exp_seq_q  <= 16'd0;
         pkt_bad_q  <= 1'b0;
         pay_err_q  <= 1'b0;
         lfsr_q     <= LFSR_SEED;
         rdy_q      <= 1'b0;
         pkt_ok_q   <= 32'd0;
         word_q     <= 32'd0;
         err_q      <= 16'd0;
         sticky_q   <= 1'b0;
         last_err_q <= 3'd0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         seq_q      <= seq_d;
         k_q        <= k_d;
         exp_seq_q  <= exp_seq_d;
         pkt_bad_q  <= pkt_bad_d;
         pay_err_q  <= pay_err_d;
         lfsr_q     <= lfsr_d;
         rdy_q      <= rdy_d;
         pkt_ok_q   <= pkt_ok_d;
         word_q     <= word_d;
         err_q      <= err_d;
         sticky_q   <= sticky_d;
         last_err_q <= last_err_d;
         busy_q     <= busy_d;
      end
   end

   assign in_rdy     = rdy_q;
   assign pkt_ok_cnt = pkt_ok_q;
   assign word_cnt   = word_q;
   assign err_cnt    = err_q;
   assign err_sticky = sticky_q;
   assign last_err   = last_err_q;
   assign busy       = busy_q;
   assign dbg_state  = state_q;

endmodule
